// File: rtl/phase_timer_pkg.sv
// -----------------------------------------------------------------------------
// phase_timer_pkg
//   Shared types and default constants for the phase_timer block.
//   - state_t     : control FSM state (IDLE / RUN)
//   - ser_state_t : serial frame shifter state (SER_IDLE / SER_SHIFT)
//   - DIV_DEF     : default clk cycles per count tick
//   - CNT_W_DEF   : default width of the count and of each serial frame
// -----------------------------------------------------------------------------
package phase_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int DIV_DEF   = 60;
  localparam int CNT_W_DEF = 8;

endpackage : phase_timer_pkg

// File: rtl/phase_timer_ser_shifter.sv
// -----------------------------------------------------------------------------
// ser_shifter
//   Emits a captured count value as a CNT_W-bit serial frame, LSB first.
//   The frame starts the cycle after the capture strobe is seen; a new
//   capture during an active frame restarts it from bit 0 with no gap in
//   ser_we. Outside a frame ser_we and ser_out are both 0.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   capture  in   1-cycle strobe: value holds a freshly updated count
//   value    in   CNT_W  count value to serialise
//   ser_out  out  serial data bit, valid while ser_we=1
//   ser_we   out  frame strobe, high for CNT_W consecutive cycles
// -----------------------------------------------------------------------------
module ser_shifter
  import phase_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [CNT_W-1:0] value,
  output logic             ser_out,
  output logic             ser_we
);

  // Bit counter must be able to hold CNT_W itself (the "frame finished" mark).
  localparam int BIT_W = $clog2(CNT_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CNT_W);

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             out_d, we_d;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    out_d   = 1'b0;
    we_d    = 1'b0;

    if (capture) begin
      // Fresh value always wins: bit 0 goes out on the next cycle, and any
      // frame in progress is simply abandoned.
      state_d = SER_SHIFT;
      we_d    = 1'b1;
      out_d   = value[0];
      shreg_d = value >> 1;
      bit_d   = BIT_W'(1);
    end else begin
      unique case (state_q)
        SER_SHIFT: begin
          if (bit_q == LAST_BIT) begin
            state_d = SER_IDLE;
            shreg_d = '0;
            bit_d   = '0;
          end else begin
            we_d    = 1'b1;
            out_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
          end
        end
        default: begin
          // SER_IDLE: outputs stay at their 0 defaults.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SER_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      bit_q   <= '0;
      ser_out <= 1'b0;
      ser_we  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      ser_out <= out_d;
      ser_we  <= we_d;
    end
  end

endmodule : ser_shifter

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   Tick-based down-counter. A clock divider produces one tick every DIV
//   running cycles; each tick decrements the count. On expiry the timer
//   either stops (RELOAD=0) or restarts from the last loaded duration
//   (RELOAD=1). Every count update is also sent out as a serial frame.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   load       in   1-cycle request: load dur and start counting
//   dur        in   CNT_W  duration in ticks, sampled with load
//   pause      in   level: freezes divider, count and state while high
//   tick       out  1-cycle pulse when the divider wraps while running
//   remaining  out  CNT_W  current count (registered)
//   done       out  1-cycle pulse on expiry (or load of a zero duration)
//   busy       out  high while in RUN
//   ser_out    out  serial count data, LSB first, valid while ser_we=1
//   ser_we     out  frame strobe, CNT_W cycles per frame
// -----------------------------------------------------------------------------
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int DIV    = DIV_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] dur,
  input  logic             pause,
  output logic             tick,
  output logic [CNT_W-1:0] remaining,
  output logic             done,
  output logic             busy,
  output logic             ser_out,
  output logic             ser_we
);

  localparam int               DIV_W       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam bit               AUTO_RELOAD = (RELOAD != 0);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             cap_q, cap_d;
  logic             running;
  logic             wrap;

  assign running = (state_q == RUN) && !pause;
  assign wrap    = running && (div_q == DIV_LAST);

  // Next-state / next-datapath logic. load has absolute priority: on a load
  // edge the divider restarts and no tick, decrement or expiry happens.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    rem_d    = rem_q;
    reload_d = reload_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    cap_d    = 1'b0;

    if (load) begin
      cap_d = 1'b1;
      div_d = '0;
      if (dur != '0) begin
        rem_d    = dur;
        reload_d = dur;
        state_d  = RUN;
      end else begin
        // A zero duration expires immediately.
        rem_d   = '0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (running) begin
      if (wrap) begin
        div_d  = '0;
        tick_d = 1'b1;
        cap_d  = 1'b1;
        if (rem_q > CNT_ONE) begin
          rem_d = rem_q - CNT_ONE;
        end else if (AUTO_RELOAD) begin
          rem_d  = reload_q;
          done_d = 1'b1;
        end else begin
          // Expiry lands on 0 and never goes below it.
          rem_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      rem_q    <= '0;
      reload_q <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      cap_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      rem_q    <= rem_d;
      reload_q <= reload_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      cap_q    <= cap_d;
    end
  end

  assign tick      = tick_q;
  assign done      = done_q;
  assign remaining = rem_q;
  assign busy      = (state_q == RUN);

  // cap_q is high for the one cycle in which rem_q holds the freshly
  // updated count, so the shifter can read remaining directly.
  ser_shifter #(
    .CNT_W (CNT_W)
  ) u_ser_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (cap_q),
    .value   (rem_q),
    .ser_out (ser_out),
    .ser_we  (ser_we)
  );

endmodule : phase_timer

// File: tb/tb_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_phase_timer
//   Drives a one-shot (RELOAD=0) and an auto-reload (RELOAD=1) phase_timer
//   with identical stimulus. A reference model derives the expected outputs
//   from elapsed running time and tick counts and pushes them into a queue;
//   a monitor pops and compares one entry after every rising edge.
// -----------------------------------------------------------------------------
module tb_phase_timer;

  localparam int DIV   = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic             tick;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] rem;
    logic             we;
    logic             so;
  } obs_t;

  typedef struct packed {
    obs_t os;
    obs_t rl;
  } pair_t;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [CNT_W-1:0] dur;
  logic             pause;

  logic             tick_a, done_a, busy_a, so_a, we_a;
  logic [CNT_W-1:0] rem_a;
  logic             tick_b, done_b, busy_b, so_b, we_b;
  logic [CNT_W-1:0] rem_b;

  phase_timer #(.DIV(DIV), .CNT_W(CNT_W), .RELOAD(0)) dut_os (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .dur       (dur),
    .pause     (pause),
    .tick      (tick_a),
    .remaining (rem_a),
    .done      (done_a),
    .busy      (busy_a),
    .ser_out   (so_a),
    .ser_we    (we_a)
  );

  phase_timer #(.DIV(DIV), .CNT_W(CNT_W), .RELOAD(1)) dut_rl (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .dur       (dur),
    .pause     (pause),
    .tick      (tick_b),
    .remaining (rem_b),
    .done      (done_b),
    .busy      (busy_b),
    .ser_out   (so_b),
    .ser_we    (we_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  pair_t exp_q[$];
  int    tick_seen  = 0;
  bit    count_tick = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t act_os();
    obs_t o;
    o = {tick_a, done_a, busy_a, rem_a, we_a, so_a};
    return o;
  endfunction

  function automatic obs_t act_rl();
    obs_t o;
    o = {tick_b, done_b, busy_b, rem_b, we_b, so_b};
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model, index 0 = one-shot, 1 = auto-reload. Remaining is derived
  // from the number of ticks since the last load; a tick occurs every DIV
  // unpaused running cycles. Serial output is described by the age of the
  // frame: a capture becomes frame bit 0 one cycle after the capture edge.
  // ---------------------------------------------------------------------------
  bit m_run[2];
  int m_dur[2];
  int m_elapsed[2];
  int m_ticks[2];
  int m_rem[2];
  int sv_val[2];
  int sv_age[2];
  bit sv_pend[2];
  int sv_pend_val[2];

  task automatic model_edge(input int r, input logic rst, input logic l,
                            input int d, input logic p, output obs_t o);
    bit t, dn, cap;
    int k;
    t = 1'b0; dn = 1'b0; cap = 1'b0;
    if (!rst) begin
      m_run[r] = 1'b0; m_dur[r] = 0; m_elapsed[r] = 0; m_ticks[r] = 0;
      m_rem[r] = 0; sv_val[r] = 0; sv_age[r] = 0; sv_pend[r] = 1'b0;
      sv_pend_val[r] = 0;
    end else begin
      if (l) begin
        cap = 1'b1;
        if (d != 0) begin
          m_run[r] = 1'b1; m_dur[r] = d; m_elapsed[r] = 0; m_ticks[r] = 0;
          m_rem[r] = d;
        end else begin
          m_run[r] = 1'b0; m_rem[r] = 0; dn = 1'b1;
        end
      end else if (m_run[r] && !p) begin
        m_elapsed[r]++;
        if (m_elapsed[r] % DIV == 0) begin
          m_ticks[r]++;
          t   = 1'b1;
          cap = 1'b1;
          if (r == 1) begin
            k        = m_ticks[r] % m_dur[r];
            m_rem[r] = (k == 0) ? m_dur[r] : m_dur[r] - k;
            dn       = (k == 0);
          end else begin
            m_rem[r] = m_dur[r] - m_ticks[r];
            if (m_rem[r] == 0) begin
              dn = 1'b1; m_run[r] = 1'b0;
            end
          end
        end
      end
      if (sv_pend[r]) begin
        sv_val[r] = sv_pend_val[r];
        sv_age[r] = 1;
      end else if (sv_age[r] != 0) begin
        sv_age[r] = (sv_age[r] >= CNT_W) ? 0 : sv_age[r] + 1;
      end
      sv_pend[r]     = cap;
      sv_pend_val[r] = m_rem[r];
    end
    o.tick = t;
    o.done = dn;
    o.busy = m_run[r];
    o.rem  = CNT_W'(m_rem[r]);
    o.we   = (sv_age[r] >= 1) && (sv_age[r] <= CNT_W);
    o.so   = o.we ? sv_val[r][sv_age[r]-1] : 1'b0;
  endtask

  // Called at a falling edge: applies inputs for the coming rising edge and
  // queues the outputs expected after it.
  task automatic step(input logic rst, input logic l, input logic [CNT_W-1:0] d, input logic p);
    pair_t e;
    obs_t  o0, o1;
    rst_n = rst;
    load  = l;
    dur   = d;
    pause = p;
    model_edge(0, rst, l, int'(d), p, o0);
    model_edge(1, rst, l, int'(d), p, o1);
    e.os = o0;
    e.rl = o1;
    exp_q.push_back(e);
    @(negedge clk);
    if (count_tick) tick_seen += int'(tick_a) + int'(tick_b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
  endtask

  // Monitor: one expected entry per rising edge, sampled just after it.
  always @(posedge clk) begin : monitor
    pair_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("oneshot_outputs", 32'(act_os()), 32'(e.os));
      check("reload_outputs",  32'(act_rl()), 32'(e.rl));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : driver
    rst_n = 1'b0;
    load  = 1'b0;
    dur   = '0;
    pause = 1'b0;
    @(negedge clk);
    #1;
    check("reset_state_os", 32'(act_os()), 32'd0);
    check("reset_state_rl", 32'(act_rl()), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    idle(3);

    // dur=3: ticks at 8/16/24 cycles, done on the third.
    step(1'b1, 1'b1, 4'd3, 1'b0);
    idle(30);

    // dur=5: frame 1,0,1,0 then 0,0,1,0 after the first tick.
    step(1'b1, 1'b1, 4'd5, 1'b0);
    idle(20);

    // Pause for 10 cycles starting 3 cycles after load.
    step(1'b1, 1'b1, 4'd3, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b1);
    idle(30);

    // Load dur=7 on the very edge of the second tick (remaining=4).
    step(1'b1, 1'b1, 4'd5, 1'b0);
    idle(15);
    step(1'b1, 1'b1, 4'd7, 1'b0);
    idle(25);

    // Zero-duration load, then dur=2 for the reload behaviour.
    step(1'b1, 1'b1, 4'd0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 4'd2, 1'b0);
    idle(50);

    // Asynchronous reset mid-run with remaining=5.
    step(1'b1, 1'b1, 4'd7, 1'b0);
    idle(16);
    check("pre_reset_remaining", 32'(rem_a), 32'd5);
    rst_n = 1'b0;
    #1;
    check("async_reset_os", 32'(act_os()), 32'd0);
    check("async_reset_rl", 32'(act_rl()), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
    count_tick = 1'b1;
    idle(20);
    count_tick = 1'b0;
    check("no_tick_after_reset", 32'(tick_seen), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      logic             l, p;
      logic [CNT_W-1:0] d;
      l = ($urandom_range(0, 24) == 0);
      d = ($urandom_range(0, 7) == 0) ? '0 : CNT_W'($urandom_range(1, 15));
      p = ($urandom_range(0, 5) == 0);
      step(1'b1, l, d, p);
    end
    idle(2);

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_phase_timer

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter DIV, default 60: clk cycles per count tick; legal range DIV >= CNT_W+2.
REQ-002 Parameter CNT_W, default 8: width of the count and of each serial frame.
REQ-003 Parameter RELOAD, default 0: 0 = one-shot, 1 = auto-reload on expiry.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 load  in  1  1-cycle request to load dur and start counting.
REQ-007 dur  in  CNT_W  duration in ticks, sampled when load=1.
REQ-008 pause  in  1  level; while high, the divider and count are frozen.
REQ-009 tick  out  1  1-cycle pulse when the divider wraps while running.
REQ-010 remaining  out  CNT_W  current count, registered.
REQ-011 done  out  1  1-cycle pulse on expiry.
REQ-012 busy  out  1  high in RUN state.
REQ-013 ser_out  out  1  serial count data, LSB first, valid while ser_we=1.
REQ-014 ser_we  out  1  frame strobe, high for exactly CNT_W consecutive cycles per frame.

Function
REQ-015 Control FSM states: IDLE, RUN. busy = (state==RUN).
REQ-016 Divider: counts 0..DIV-1 in RUN with pause=0; holds otherwise.
REQ-017 tick is registered; it pulses on the edge at which the divider wraps DIV-1 -> 0.
REQ-018 load=1 with dur!=0:
- remaining <= dur, reload register <= dur, divider <= 0, state <= RUN.
- Applies from either state.
- Takes priority over a coincident tick; no tick, decrement or done on that edge.
REQ-019 load=1 with dur==0: remaining <= 0, state <= IDLE, done pulses on the same edge.
REQ-020 At each tick with remaining>1: remaining decrements by 1.
REQ-021 At each tick with remaining==1 and RELOAD=0: remaining <= 0, state <= IDLE, done pulses; tick pulses on the same edge.
REQ-022 At each tick with remaining==1 and RELOAD=1: remaining <= reload register, state stays RUN, done pulses.
REQ-023 Pause:
- Freezes the divider, remaining and state; no tick is generated.
- load still acts during pause.
- The serializer is not frozen.
REQ-024 Serial capture: every edge that updates remaining (load or tick) also captures the new remaining value.
REQ-025 Serial frame:
- Starts the cycle after capture.
- ser_we=1 and ser_out=bit i during frame cycle i, i=0..CNT_W-1.
- Then ser_we=0 and ser_out=0.
REQ-026 A capture during an active frame aborts it and restarts from bit 0 with the new value; ser_we stays high with no gap.
REQ-027 No arithmetic wrap: remaining never decrements below 0; divider width is clog2(DIV).

Reset
REQ-028 rst_n=0 asynchronously forces:
- state IDLE, divider 0, remaining 0, reload register 0;
- tick, done, busy, ser_out, ser_we all 0.
REQ-029 Reset mid-frame or mid-run drops ser_we and busy immediately; no frame resumes after release.
REQ-030 The first edge after release is a normal IDLE cycle; the block stays idle until load.

Structure
REQ-031 Package phase_timer_pkg holds:
- the control FSM state type (IDLE, RUN);
- the serializer state type (SER_IDLE, SER_SHIFT);
- default constants DIV_DEF=60, CNT_W_DEF=8.
REQ-032 One sub-module, ser_shifter:
- Parameter CNT_W.
- Inputs: capture strobe and value.
- Outputs: ser_out, ser_we.
- Implements REQ-025/026.

Verification (DIV=8, CNT_W=4 unless stated)
REQ-033 Assert rst_n=0 mid-run with remaining=5 -> all outputs 0 immediately; after release, no tick for 20 cycles.
REQ-034 load dur=3 -> ticks at 8, 16 and 24 cycles after load; remaining goes 3,2,1,0; done and busy fall on the third tick edge.
REQ-035 load dur=5 -> ser_we high cycles 1-4 after load, ser_out=1,0,1,0; after tick 1, a frame 0,0,1,0 (value 4).
REQ-036 pause high for 10 cycles starting 3 cycles after load dur=3 -> first tick at cycle 18; remaining=3 throughout pause.
REQ-037 RELOAD=1, load dur=2 -> remaining 2,1,2,1,...; done every 16 cycles; busy stays 1.
REQ-038 load dur=7 on the same edge as a tick, with remaining=4 -> remaining=7, no done, divider restarts (next tick 8 cycles later); frame restarted with 1,1,1,0.
